// File: rtl/turbo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | turbo_pkg                                                                  |
// | Shared turbo-code types, constants and the 16-bit interleaver functions.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package turbo_pkg;

    localparam int          WORD_W          = 16;
    localparam logic [15:0] PUNCT_EVEN_MASK = 16'h5555;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_CAPT = 2'd2,
        ST_OUT  = 2'd3
    } enc_state_t;

    // Output bit i takes input bit (5*i mod 16); 5 is odd, so this is a bijection.
    function automatic logic [WORD_W-1:0] il16(input logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_W; i++) begin
            r[4'(i)] = d[4'((5 * i) % WORD_W)];
        end
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] deil16(input logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_W; i++) begin
            r[4'((5 * i) % WORD_W)] = d[4'(i)];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_il16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | turbo_il16                                                                 |
// | Combinational 16-bit turbo interleaver (wrapper around turbo_pkg::il16).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module turbo_il16
    import turbo_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o
);

    assign data_o = il16(data_i);

endmodule
`default_nettype wire

// File: rtl/turbo_enc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | turbo_enc_ctrl                                                             |
// | Sequences one word at a time through the RSC pair and returns the results. |
// | Define TURBO_ENC_PUNCT_EN for rate-1/2 puncturing at capture.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module turbo_enc_ctrl
    import turbo_pkg::*;
#(
    parameter int RSC_LAT     = 2,
    parameter int FRAME_WORDS = 8
) (
    input  logic              clk_p_i,
    input  logic              reset_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] enc_data_o,
    output logic [WORD_W-1:0] enc_il_data_o,
    input  logic [WORD_W-1:0] enc_sys_i,
    input  logic [WORD_W-1:0] enc_p1_i,
    input  logic [WORD_W-1:0] enc_p2_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] sys_o,
    output logic [WORD_W-1:0] par1_o,
    output logic [WORD_W-1:0] par2_o,
    output logic              out_last_o,
    output logic              busy_o
);

    localparam logic [3:0] c_LAT_INIT  = 4'(RSC_LAT - 1);
    localparam logic [7:0] c_LAST_WORD = 8'(FRAME_WORDS - 1);

    enc_state_t        r_state;
    enc_state_t        w_state_nxt;
    logic [3:0]        r_lat_cnt;
    logic [7:0]        r_word_cnt;
    logic [WORD_W-1:0] w_il_data;
    logic [WORD_W-1:0] w_par1_cap;
    logic [WORD_W-1:0] w_par2_cap;

    turbo_il16 u_il16 (
        .data_i (data_i),
        .data_o (w_il_data)
    );

`ifdef TURBO_ENC_PUNCT_EN
    assign w_par1_cap = (enc_p1_i & PUNCT_EVEN_MASK) | (enc_p2_i & ~PUNCT_EVEN_MASK);
    assign w_par2_cap = '0;
`else
    assign w_par1_cap = enc_p1_i;
    assign w_par2_cap = enc_p2_i;
`endif

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: if (r_lat_cnt == 4'd0) w_state_nxt = ST_CAPT;
            ST_CAPT: w_state_nxt = ST_OUT;
            ST_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= ST_IDLE;
            r_lat_cnt     <= 4'd0;
            r_word_cnt    <= 8'd0;
            enc_data_o    <= '0;
            enc_il_data_o <= '0;
            sys_o         <= '0;
            par1_o        <= '0;
            par2_o        <= '0;
            out_last_o    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        enc_data_o    <= data_i;
                        enc_il_data_o <= w_il_data;
                        r_lat_cnt     <= c_LAT_INIT;
                    end
                end
                ST_HOLD: begin
                    if (r_lat_cnt != 4'd0) r_lat_cnt <= r_lat_cnt - 4'd1;
                end
                ST_CAPT: begin
                    sys_o      <= enc_sys_i;
                    par1_o     <= w_par1_cap;
                    par2_o     <= w_par2_cap;
                    out_last_o <= (r_word_cnt == c_LAST_WORD);
                end
                ST_OUT: begin
                    // Word count advances only on the output handshake.
                    if (out_ready_i) begin
                        r_word_cnt <= (r_word_cnt == c_LAST_WORD) ? 8'd0 : r_word_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_turbo_enc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_turbo_enc_ctrl                                                          |
// | Randomized self-checking bench with a stub RSC pair and a reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_turbo_enc_ctrl;

    localparam int RSC_LAT     = 2;
    localparam int FRAME_WORDS = 4;

    logic        clk_p_i     = 1'b0;
    logic        reset_n_i   = 1'b0;
    logic        in_valid_i  = 1'b0;
    logic        out_ready_i = 1'b0;
    logic [15:0] data_i      = 16'h0000;
    logic        in_ready_o, out_valid_o, out_last_o, busy_o;
    logic [15:0] enc_data_o, enc_il_data_o, enc_sys_i, enc_p1_i, enc_p2_i;
    logic [15:0] sys_o, par1_o, par2_o;

    int n_checks  = 0;
    int n_fail    = 0;
    int model_cnt = 0;

    // Stub RSC pair: systematic passthrough and simple XOR parities.
    assign enc_sys_i = enc_data_o;
    assign enc_p1_i  = enc_data_o ^ 16'hA5A5;
    assign enc_p2_i  = enc_il_data_o ^ 16'h3C3C;

    turbo_enc_ctrl #(
        .RSC_LAT     (RSC_LAT),
        .FRAME_WORDS (FRAME_WORDS)
    ) dut (
        .clk_p_i       (clk_p_i),
        .reset_n_i     (reset_n_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .data_i        (data_i),
        .enc_data_o    (enc_data_o),
        .enc_il_data_o (enc_il_data_o),
        .enc_sys_i     (enc_sys_i),
        .enc_p1_i      (enc_p1_i),
        .enc_p2_i      (enc_p2_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .sys_o         (sys_o),
        .par1_o        (par1_o),
        .par2_o        (par2_o),
        .out_last_o    (out_last_o),
        .busy_o        (busy_o)
    );

    always #5 clk_p_i = ~clk_p_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Input bit j lands on output bit 13*j mod 16 (13 is the inverse of 5 mod 16).
    function automatic logic [15:0] ref_il(input logic [15:0] d);
        logic [15:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[(13 * j) % 16] = d[j];
        return r;
    endfunction

    function automatic logic [15:0] ref_par1(input logic [15:0] d);
        logic [15:0] p1, p2, r;
        p1 = d ^ 16'hA5A5;
        p2 = ref_il(d) ^ 16'h3C3C;
`ifdef TURBO_ENC_PUNCT_EN
        for (int i = 0; i < 16; i++) r[i] = (i % 2 == 0) ? p1[i] : p2[i];
`else
        r = p1;
        if (p2 == 16'hFFFF) r = p1; // p2 unused in rate 1/3
`endif
        return r;
    endfunction

    function automatic logic [15:0] ref_par2(input logic [15:0] d);
`ifdef TURBO_ENC_PUNCT_EN
        if (d == 16'h0000) return 16'h0000;
        return 16'h0000;
`else
        return ref_il(d) ^ 16'h3C3C;
`endif
    endfunction

    task automatic send_word(input logic [15:0] d, input int stall);
        int n;
        @(negedge clk_p_i);
        in_valid_i = 1'b1;
        data_i     = d;
        n = 0;
        while (!in_ready_o && n < 100) begin
            @(negedge clk_p_i);
            n++;
        end
        check("in_ready_idle", 32'(in_ready_o), 32'd1);
        @(negedge clk_p_i);
        in_valid_i = 1'b0;
        data_i     = ~d;
        check("enc_data", 32'(enc_data_o), 32'(d));
        check("enc_il_data", 32'(enc_il_data_o), 32'(ref_il(d)));
        check("in_ready_busy", 32'(in_ready_o), 32'd0);
        check("busy", 32'(busy_o), 32'd1);
        n = 1;
        while (!out_valid_o && n < 50) begin
            @(negedge clk_p_i);
            n++;
        end
        check("latency", 32'(n), 32'(RSC_LAT + 2));
        check("sys", 32'(sys_o), 32'(d));
        check("par1", 32'(par1_o), 32'(ref_par1(d)));
        check("par2", 32'(par2_o), 32'(ref_par2(d)));
        check("last", 32'(out_last_o), 32'(model_cnt == FRAME_WORDS - 1));
        // A competing word must not be accepted while the result is stalled.
        in_valid_i = 1'b1;
        data_i     = d ^ 16'hFFFF;
        repeat (stall) @(negedge clk_p_i);
        if (stall > 0) begin
            check("bp_valid", 32'(out_valid_o), 32'd1);
            check("bp_in_ready", 32'(in_ready_o), 32'd0);
            check("bp_par1", 32'(par1_o), 32'(ref_par1(d)));
            check("bp_enc_data", 32'(enc_data_o), 32'(d));
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_p_i);
        out_ready_i = 1'b0;
        check("in_ready_after_hs", 32'(in_ready_o), 32'd1);
        check("valid_after_hs", 32'(out_valid_o), 32'd0);
        model_cnt = (model_cnt + 1) % FRAME_WORDS;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_p_i);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_words", {enc_data_o, enc_il_data_o}, 32'd0);
        check("rst_results", {sys_o | par1_o, par2_o}, 32'd0);
        reset_n_i = 1'b1;

        send_word(16'h0002, 0);
        send_word(16'h0001, 0);
        send_word(16'hFFFF, 0);
        send_word(16'h1234, 10);
        for (int k = 0; k < 5; k++) send_word(16'($urandom), int'($urandom_range(0, 3)));

        // Reset while a result is being presented.
        @(negedge clk_p_i);
        in_valid_i = 1'b1;
        data_i     = 16'($urandom);
        n = 0;
        while (!out_valid_o && n < 50) begin
            @(negedge clk_p_i);
            n++;
        end
        in_valid_i = 1'b0;
        check("pre_reset_valid", 32'(out_valid_o), 32'd1);
        #2 reset_n_i = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid_o), 32'd0);
        check("arst_in_ready", 32'(in_ready_o), 32'd1);
        check("arst_par1", 32'(par1_o), 32'd0);
        @(negedge clk_p_i);
        reset_n_i = 1'b1;
        model_cnt = 0;

        for (int k = 0; k < 6; k++) send_word(16'($urandom), int'($urandom_range(0, 2)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
